// File: rtl/sram_line_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_line_ctrl_pkg
//   Shared definitions for the SRAM line controller:
//     - state_e          : controller FSM state encoding
//     - BASE_OFFSET_DEF  : default host byte address mapped to SRAM halfword 0
//     - cnt_w()          : counter width for a modulo-n counter (never < 1 bit)
// ---------------------------------------------------------------------------
package sram_line_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int unsigned BASE_OFFSET_DEF = 1024;

    // Width needed to count 0..n-1; a 1-state counter still gets one bit so
    // the port/register declarations stay legal.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// ---------------------------------------------------------------------------
// sram_beat_timer
//   Paces a burst: each beat lasts WAIT+1 cycles, beats run 0..BEATS-1.
//   Counters sit at zero whenever en_i is low, so every burst starts clean.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en_i          count while high (controller is in ACCESS)
//   beat_o        current beat index
//   last_cycle_o  this is the final cycle of the current beat
//   last_beat_o   current beat is the final beat of the line
// ---------------------------------------------------------------------------
module sram_beat_timer
    import sram_line_ctrl_pkg::*;
#(
    parameter  int unsigned WAIT  = 1,
    parameter  int unsigned BEATS = 4,
    localparam int unsigned CW    = cnt_w(WAIT + 1),
    localparam int unsigned BW    = cnt_w(BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [BW-1:0] beat_o,
    output logic          last_cycle_o,
    output logic          last_beat_o
);

    logic [CW-1:0] cnt_q;
    logic [BW-1:0] beat_q;

    assign last_cycle_o = (cnt_q == CW'(WAIT));
    assign last_beat_o  = (beat_q == BW'(BEATS - 1));
    assign beat_o       = beat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            beat_q <= '0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            beat_q <= '0;
        end else if (last_cycle_o) begin
            cnt_q  <= '0;
            beat_q <= last_beat_o ? '0 : beat_q + BW'(1);
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/sram_line_ctrl.sv
// ---------------------------------------------------------------------------
// sram_line_ctrl
//   Moves one LINE_W-bit host line to/from an asynchronous SRAM as a burst of
//   SRAM_DW-bit beats, WAIT+1 cycles per beat. ready doubles as the pipeline
//   freeze: it drops combinationally the moment a request appears in IDLE.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rd_en, wr_en          line read / write request, held until ready
//   addr                  host byte address (held while pending)
//   wdata                 write line, beat b = wdata[b*SRAM_DW +: SRAM_DW]
//   rdata                 last completed read line
//   ready                 idle-and-no-request or access complete
//   SRAM_DQ               bidirectional SRAM data
//   SRAM_ADDR             SRAM halfword address
//   SRAM_WE_N             write strobe, active low
//   SRAM_UB_N/LB_N/CE_N/OE_N  permanently enabled (0)
// ---------------------------------------------------------------------------
module sram_line_ctrl
    import sram_line_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned SRAM_DW     = 16,
    parameter int unsigned LINE_W      = 64,
    parameter int unsigned WAIT        = 1,
    parameter int unsigned BASE_OFFSET = BASE_OFFSET_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [LINE_W-1:0]  wdata,
    output logic [LINE_W-1:0]  rdata,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]  SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int unsigned BEATS = LINE_W / SRAM_DW;
    localparam int unsigned BW    = cnt_w(BEATS);
    localparam int unsigned SHIFT = $clog2(SRAM_DW / 8);  // bytes -> SRAM words
    localparam int unsigned ALIGN = $clog2(BEATS);        // line alignment bits

    state_e              state_q;
    logic                wr_drive_q;   // write burst in flight: drives DQ, WE_N low
    logic [ADDR_W-1:0]   base_q;
    logic [LINE_W-1:0]   rbuf_q;       // read beats collected so far
    logic [LINE_W-1:0]   rbuf_d;
    logic [LINE_W-1:0]   rdata_q;

    logic [BW-1:0]       beat;
    logic                last_cycle;
    logic                last_beat;

    logic [31:0]         off;
    logic [31:0]         word_idx;
    logic [ADDR_W-1:0]   base_d;
    logic                unused_hi;

    // Host byte address -> line-aligned SRAM word address; wraps modulo
    // 2^ADDR_W by plain truncation.
    assign off       = addr - 32'(BASE_OFFSET);
    assign word_idx  = (off >> SHIFT) & ~((32'd1 << ALIGN) - 32'd1);
    assign base_d    = word_idx[ADDR_W-1:0];
    assign unused_hi = ^word_idx[31:ADDR_W];

    sram_beat_timer #(
        .WAIT  (WAIT),
        .BEATS (BEATS)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .en_i         (state_q == ACCESS),
        .beat_o       (beat),
        .last_cycle_o (last_cycle),
        .last_beat_o  (last_beat)
    );

    // Current read beat merged into the collection buffer. The final beat
    // goes straight to rdata so the line appears exactly on entry to DONE,
    // and rdata is never left holding a half-updated line.
    always_comb begin
        rbuf_d = rbuf_q;
        rbuf_d[int'(beat)*SRAM_DW +: SRAM_DW] = SRAM_DQ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_drive_q <= 1'b0;
            base_q     <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_en || wr_en) begin
                        wr_drive_q <= wr_en;   // write wins a rd/wr conflict
                        base_q     <= base_d;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!wr_drive_q && last_cycle) begin
                        rbuf_q <= rbuf_d;
                        if (last_beat) rdata_q <= rbuf_d;
                    end
                    if (last_cycle && last_beat) begin
                        wr_drive_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready     = (state_q == IDLE) ? ~(rd_en | wr_en) : (state_q == DONE);
    assign rdata     = rdata_q;
    assign SRAM_ADDR = base_q + ADDR_W'(beat);
    assign SRAM_WE_N = ~wr_drive_q;
    assign SRAM_DQ   = wr_drive_q ? wdata[int'(beat)*SRAM_DW +: SRAM_DW] : 'z;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_line_ctrl.sv
module tb_sram_line_ctrl;

  localparam int AW = 18, DW = 16, LW = 64, WT = 1;
  localparam int BEATS = LW / DW, N = BEATS * (WT + 1);

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance 1: default parameters ----------------
  logic          rd_en = 0, wr_en = 0;
  logic [31:0]   addr = '0;
  logic [LW-1:0] wdata = '0, rdata;
  logic          ready, we_n, ub_n, lb_n, ce_n, oe_n;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] dq;

  sram_line_ctrl dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_DQ(dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n));

  // ---------------- instance 2: WAIT=0, 32-bit line ----------------
  logic        rd2 = 0, wr2 = 0;
  logic [31:0] addr2 = '0, wdata2 = '0, rdata2;
  logic        ready2, we2_n, ub2_n, lb2_n, ce2_n, oe2_n;
  logic [AW-1:0] sram_addr2;
  wire  [DW-1:0] dq2;

  sram_line_ctrl #(.LINE_W(32), .WAIT(0)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd2), .wr_en(wr2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .ready(ready2), .SRAM_DQ(dq2),
    .SRAM_ADDR(sram_addr2), .SRAM_WE_N(we2_n), .SRAM_UB_N(ub2_n),
    .SRAM_LB_N(lb2_n), .SRAM_CE_N(ce2_n), .SRAM_OE_N(oe2_n));

  // ---------------- SRAM models and reference memory ----------------
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] mem2    [0:255];
  logic          init_done = 1'b0;

  assign dq  = we_n  ? mem[sram_addr]        : {DW{1'bz}};
  assign dq2 = we2_n ? mem2[sram_addr2[7:0]] : {DW{1'bz}};

  function automatic logic [DW-1:0] mem_init(input int i);
    if (i < 4) return 16'(16'h1111 * (i + 1));
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] mem2_init(input int i);
    if (i == 0) return 16'hAAAA;
    if (i == 1) return 16'h5555;
    return 16'(i * 257);
  endfunction

  // Line-aligned SRAM word index of a host byte address.
  function automatic logic [AW-1:0] base_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 2;
    return AW'(w - (w % BEATS));
  endfunction

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model state (written by stimulus) ----------------
  bit            t_act = 0, t_wr = 0;
  int            t_start = 0;
  logic [AW-1:0] t_base = '0;
  logic [LW-1:0] t_wd = '0;

  // ---------------- SRAM writes + per-cycle compare against the model ----------------
  logic [LW-1:0] rdata_exp = '0;
  logic [LW-1:0] cline;
  int            ck, cb;

  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < (1 << AW); i++) begin
        mem[i]     <= mem_init(i);
        ref_mem[i] <= mem_init(i);
      end
      for (int i = 0; i < 256; i++) mem2[i] <= mem2_init(i);
      init_done <= 1'b1;
    end else begin
      if (!we_n)  mem[sram_addr]         <= dq;
      if (!we2_n) mem2[sram_addr2[7:0]]  <= dq2;
    end

    if (rst) begin
      rdata_exp <= '0;
    end else if (init_done) begin
      if (!t_act) begin
        chk("idle_ready", ready, 1'b1);
        chk("idle_we_n", we_n, 1'b1);
        chk("idle_rdata", rdata, rdata_exp);
      end else begin
        ck = cyc - t_start;
        if (ck == 0) begin
          chk("req_ready", ready, 1'b0);
          chk("req_we_n", we_n, 1'b1);
          chk("req_rdata", rdata, rdata_exp);
        end else if (ck <= N) begin
          cb = (ck - 1) / (WT + 1);
          chk("busy_ready", ready, 1'b0);
          chk("busy_rdata", rdata, rdata_exp);
          chk("busy_addr", sram_addr, AW'(t_base + cb));
          chk("busy_we_n", we_n, !t_wr);
          if (t_wr) begin
            chk("busy_dq", dq, t_wd[cb*DW +: DW]);
            if ((ck - 1) % (WT + 1) == WT)
              ref_mem[AW'(t_base + cb)] <= t_wd[cb*DW +: DW];
          end
        end else if (ck == N + 1) begin
          chk("done_ready", ready, 1'b1);
          chk("done_we_n", we_n, 1'b1);
          if (t_wr) begin
            for (int b = 0; b < BEATS; b++)
              chk("sram_line", mem[AW'(t_base + b)], t_wd[b*DW +: DW]);
            chk("done_rdata_kept", rdata, rdata_exp);
          end else begin
            for (int b = 0; b < BEATS; b++)
              cline[b*DW +: DW] = ref_mem[AW'(t_base + b)];
            rdata_exp <= cline;
            chk("done_rdata", rdata, cline);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0]   rdy_hist, wel_hist;
  logic [AW-1:0] addr_hist [0:15];
  int            exp_steps [0:7] = '{0, 0, 1, 1, 2, 2, 3, 3};

  // Called just after a posedge; returns just after the edge that ends DONE.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [LW-1:0] wd);
    rd_en = rd; wr_en = wr; addr = a; wdata = wd;
    t_wr = wr; t_base = base_of(a); t_wd = wd; t_start = cyc; t_act = 1;
    for (int k = 0; k <= N + 1; k++) begin
      @(negedge clk);
      rdy_hist[k] = ready; wel_hist[k] = !we_n; addr_hist[k] = sram_addr;
      @(posedge clk);
    end
    #1 rd_en = 0; wr_en = 0; t_act = 0;
  endtask

  task automatic txn2(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [3:0] rh, output logic [3:0] wl,
                      output logic [AW-1:0] a1, output logic [AW-1:0] a2);
    rd2 = !wr; wr2 = wr; addr2 = a; wdata2 = wd;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rh[k] = ready2; wl[k] = !we2_n;
      if (k == 1) a1 = sram_addr2;
      if (k == 2) a2 = sram_addr2;
      @(posedge clk);
    end
    #1 rd2 = 0; wr2 = 0;
  endtask

  logic [3:0]    rh, wl;
  logic [AW-1:0] a1, a2;

  initial begin
    // Reset asserted mid-cycle: outputs must take reset values at once.
    #1 rst = 1;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_we_n", we_n, 1'b1);
    chk("rst_addr", sram_addr, '0);
    chk("rst_rdata", rdata, '0);
    chk("tie_ctrl", {ub_n, lb_n, ce_n, oe_n, ub2_n, lb2_n, ce2_n, oe2_n}, 8'h00);
    @(negedge clk); @(negedge clk); #1 rst = 0;
    @(posedge clk); #1;

    // Directed read of the first line.
    txn(1, 0, 32'd1024, '0);
    chk("rd_ready_cycles", rdy_hist[9:0], 10'b10_0000_0000);
    chk("rd_rdata_lit", rdata, 64'h4444_3333_2222_1111);
    for (int k = 1; k <= 8; k++) chk("rd_addr_step", addr_hist[k], AW'(exp_steps[k-1]));

    // Directed write, then reset in idle, then read back.
    @(posedge clk); #1;
    txn(0, 1, 32'd1032, 64'hDEAD_BEEF_CAFE_F00D);
    chk("wr_we_low", wel_hist[9:0], 10'b01_1111_1110);
    chk("wr_mem", {mem[7], mem[6], mem[5], mem[4]}, 64'hDEAD_BEEF_CAFE_F00D);

    @(posedge clk); #2 rst = 1;
    #1;
    chk("rst2_rdata", rdata, '0);
    chk("rst2_addr", sram_addr, '0);
    chk("rst2_ready", ready, 1'b1);
    @(negedge clk); #1 rst = 0;
    @(posedge clk); #1;

    txn(1, 0, 32'd1032, '0);
    chk("rd_back_lit", rdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Unaligned address with rd/wr conflict: write wins, line-aligned.
    @(posedge clk); #1;
    txn(1, 1, 32'd1038, 64'h0123_4567_89AB_CDEF);
    chk("conf_mem", {mem[7], mem[6], mem[5], mem[4]}, 64'h0123_4567_89AB_CDEF);
    chk("conf_rdata", rdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Reset during write beat 2: beats 0,1 land, 2,3 never touched.
    @(posedge clk); #1;
    wr_en = 1; addr = 32'd1032; wdata = 64'h1234_5678_9ABC_DEF0;
    t_wr = 1; t_base = base_of(32'd1032); t_wd = wdata; t_start = cyc; t_act = 1;
    repeat (5) @(posedge clk);
    #2 rst = 1; t_act = 0;
    #1;
    chk("abort_we_n", we_n, 1'b1);
    chk("abort_addr", sram_addr, '0);
    chk("abort_rdata", rdata, '0);
    chk("abort_ready_req", ready, 1'b0);
    wr_en = 0;
    #1 chk("abort_ready", ready, 1'b1);
    @(negedge clk); #1 rst = 0;
    chk("abort_mem", {mem[7], mem[6], mem[5], mem[4]}, 64'h0123_4567_9ABC_DEF0);
    @(posedge clk); #1;
    txn(1, 0, 32'd1032, '0);
    chk("abort_readback", rdata, 64'h0123_4567_9ABC_DEF0);

    // Randomized traffic, including addresses below the base that wrap.
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023))
                                      : 32'd1024 + 32'($urandom_range(0, 600));
      @(posedge clk); #1;
      txn(op != 1, op != 0, a, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Variant: WAIT=0, 32-bit line -> 2 single-cycle beats, ready in cycle 3.
    @(posedge clk); #1;
    txn2(0, 32'd1024, '0, rh, wl, a1, a2);
    chk("v_rd_ready", rh, 4'b1000);
    chk("v_rd_addr", {a2, a1}, {AW'(1), AW'(0)});
    chk("v_rd_rdata", rdata2, 32'h5555_AAAA);
    @(posedge clk); #1;
    txn2(1, 32'd1028, 32'h1234_5678, rh, wl, a1, a2);
    chk("v_wr_ready", rh, 4'b1000);
    chk("v_wr_we", wl, 4'b0110);
    chk("v_wr_addr", {a2, a1}, {AW'(3), AW'(2)});
    chk("v_wr_mem", {mem2[3], mem2[2]}, 32'h1234_5678);
    chk("v_wr_rdata", rdata2, 32'h5555_AAAA);
    @(posedge clk); #1;
    txn2(0, 32'd1028, '0, rh, wl, a1, a2);
    chk("v_rd2_rdata", rdata2, 32'h1234_5678);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
